// File: rtl/dclkfifolut_pkg.sv
// Shared definitions for the dual-clock LUT FIFO write-port arbiter.
package dclkfifolut_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Ceiling log2 with a floor of 1 so a 2-requester grant id is still one bit wide.
    function automatic int unsigned clog2(input int unsigned v);
        clog2 = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) clog2 = i + 1;
        end
    endfunction

endpackage

// File: rtl/dclkfifolut_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at index >= ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               any_req,
    output logic [IDW-1:0]     pick
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;
    logic                 found;

    // The upper copy is unmasked, so the lowest surviving bit is the wrapped winner.
    assign dbl     = {req, req};
    assign masked  = dbl & ({(2*NUM_REQ){1'b1}} << ptr);
    assign any_req = |req;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < 2*NUM_REQ; j++) begin
            if (masked[j] && !found) begin
                found = 1'b1;
                pick  = (j >= NUM_REQ) ? IDW'(j - NUM_REQ) : IDW'(j);
            end
        end
    end

endmodule

// File: rtl/dclkfifolut_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among NUM_REQ requesters.
module dclkfifolut_wr_arbiter
    import dclkfifolut_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int FIFO_WIDTH      = 8,
    parameter int LOG2_FIFO_DEPTH = 3,
    parameter int MIN_FREE        = 1
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ-1:0]               req_last,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             grant_valid,
    output logic [clog2(NUM_REQ)-1:0]        grant_id,
    output logic                             fifo_wen,
    output logic [FIFO_WIDTH-1:0]            fifo_wdata,
    input  logic                             fifo_wfull,
    input  logic [LOG2_FIFO_DEPTH:0]         fifo_wlevel,
    output logic [15:0]                      pkt_cnt
);

    localparam int IDW = clog2(NUM_REQ);
    localparam int LW  = LOG2_FIFO_DEPTH + 1;

    state_t         state, state_nx;
    logic [IDW-1:0] gid_nx;
    logic [IDW-1:0] rr_ptr, rr_nx;
    logic [15:0]    pkt_nx;
    logic [LW-1:0]  free;
    logic           admit;
    logic [NUM_REQ-1:0] cand;
    logic           any_req;
    logic [IDW-1:0] pick;

    assign free  = LW'(2**LOG2_FIFO_DEPTH) - fifo_wlevel;
    assign admit = (MIN_FREE == 0) || (free >= LW'(MIN_FREE));
    assign cand  = req_valid & {NUM_REQ{admit}};

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req     (cand),
        .ptr     (rr_ptr),
        .any_req (any_req),
        .pick    (pick)
    );

    assign grant_valid = (state == BUSY);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            pkt_cnt  <= '0;
        end else begin
            state    <= state_nx;
            grant_id <= gid_nx;
            rr_ptr   <= rr_nx;
            pkt_cnt  <= pkt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        gid_nx     = grant_id;
        rr_nx      = rr_ptr;
        pkt_nx     = pkt_cnt;
        req_ready  = '0;
        fifo_wen   = 1'b0;
        fifo_wdata = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gid_nx   = pick;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                req_ready[grant_id] = ~fifo_wfull;
                fifo_wen = req_valid[grant_id] & ~fifo_wfull;
                if (fifo_wen) fifo_wdata = req_data[grant_id*FIFO_WIDTH +: FIFO_WIDTH];
                // Grant is released only by a transferred last beat; bubbles keep it.
                if (fifo_wen && req_last[grant_id]) begin
                    state_nx = IDLE;
                    rr_nx    = (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
                    pkt_nx   = pkt_cnt + 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dclkfifolut_wr_arbiter.sv
// Directed bench for dclkfifolut_wr_arbiter with a queue-based FIFO and a behavioural arbiter model.
module tb_dclkfifolut_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int L     = 3;
    localparam int MF    = 1;
    localparam int DEPTH = 8;
    localparam int LW    = L + 1;

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_last, req_ready, vld_q, bubble;
    logic [N*W-1:0] req_data;
    logic           grant_valid;
    logic [1:0]     grant_id;
    logic           fifo_wen;
    logic [W-1:0]   fifo_wdata;
    logic           fifo_wfull;
    logic [L:0]     fifo_wlevel;
    logic [15:0]    pkt_cnt;

    assign req_valid = vld_q & ~bubble;

    dclkfifolut_wr_arbiter #(
        .NUM_REQ         (N),
        .FIFO_WIDTH      (W),
        .LOG2_FIFO_DEPTH (L),
        .MIN_FREE        (MF)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .fifo_wen    (fifo_wen),
        .fifo_wdata  (fifo_wdata),
        .fifo_wfull  (fifo_wfull),
        .fifo_wlevel (fifo_wlevel),
        .pkt_cnt     (pkt_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // FIFO stand-in: depth 8, level seen by the arbiter updates after each edge.
    logic [W-1:0] fq[$];
    logic [W-1:0] rd_log[$];
    logic         rd_en = 1'b0;
    logic [L:0]   fcnt = '0;
    assign fifo_wlevel = fcnt;
    assign fifo_wfull  = (fcnt == LW'(DEPTH));

    always @(posedge clk) begin
        if (rd_en && fq.size() > 0) begin
            rd_log.push_back(fq[0]);
            void'(fq.pop_front());
        end
        if (fifo_wen) fq.push_back(fifo_wdata);
        fcnt <= LW'(fq.size());
    end

    // Requester sources: each queue entry is {last, data}.
    logic [W:0] srcq[N][$];
    int         xfer_cnt[N];
    logic [N-1:0] xs;

    initial begin
        vld_q = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < N; i++) xfer_cnt[i] = 0;
        forever begin
            @(negedge clk);
            xs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                logic [W:0] hd;
                if (xs[i]) begin
                    void'(srcq[i].pop_front());
                    xfer_cnt[i]++;
                end
                if (srcq[i].size() > 0) begin
                    hd = srcq[i][0];
                    vld_q[i] = 1'b1;
                    req_data[i*W +: W] = hd[W-1:0];
                    req_last[i] = hd[W];
                end else begin
                    vld_q[i] = 1'b0;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    // Behavioural model: who owns the port, the rotation start, packets done.
    bit m_busy, n_busy, rst_seen;
    int m_g, m_rr, m_pkt, n_g, n_rr, n_pkt;
    int wen_cnt = 0;

    always @(posedge arst) rst_seen = 1'b1;

    initial begin
        logic [N-1:0] e_ready;
        logic         e_wen;
        logic [W-1:0] e_wd;
        bit           found;
        int           idx;
        m_busy = 0; m_g = 0; m_rr = 0; m_pkt = 0;
        forever begin
            @(negedge clk);
            if (rst_seen || arst) begin
                m_busy = 0; m_g = 0; m_rr = 0; m_pkt = 0; rst_seen = 0;
            end
            e_ready = '0; e_wen = 1'b0; e_wd = '0;
            if (m_busy) begin
                e_ready[m_g] = ~fifo_wfull;
                e_wen = req_valid[m_g] & ~fifo_wfull;
                if (e_wen) e_wd = req_data[m_g*W +: W];
            end
            chk("grant_valid", 32'(grant_valid), 32'(m_busy));
            chk("grant_id", 32'(grant_id), 32'(m_g));
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("fifo_wen", 32'(fifo_wen), 32'(e_wen));
            chk("fifo_wdata", 32'(fifo_wdata), 32'(e_wd));
            chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt % 65536));
            if (fifo_wen) wen_cnt++;
            n_busy = m_busy; n_g = m_g; n_rr = m_rr; n_pkt = m_pkt;
            if (!m_busy) begin
                found = 0;
                if (DEPTH - int'(fifo_wlevel) >= MF) begin
                    for (int k = 0; k < N; k++) begin
                        idx = (m_rr + k) % N;
                        if (req_valid[idx] && !found) begin
                            found = 1; n_g = idx; n_busy = 1;
                        end
                    end
                end
            end else if (e_wen && req_last[m_g]) begin
                n_busy = 0; n_rr = (m_g + 1) % N; n_pkt = m_pkt + 1;
            end
            @(posedge clk);
            if (arst) begin
                m_busy = 0; m_g = 0; m_rr = 0; m_pkt = 0;
            end else begin
                m_busy = n_busy; m_g = n_g; m_rr = n_rr; m_pkt = n_pkt;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 arst = 1'b1;
        @(posedge clk); #2 arst = 1'b0;
        rd_log.delete();
        wen_cnt = 0;
    endtask

    task automatic push_beat(input int r, input logic last, input logic [W-1:0] d);
        srcq[r].push_back({last, d});
    endtask

    task automatic wait_grant(input string nm);
        bit ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (grant_valid) ok = 1;
        end
        if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_xfer(input int r, input int target, input string nm);
        bit ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk); #2;
            if (xfer_cnt[r] >= target) ok = 1;
        end
        if (!ok) chk({nm, "_timeout"}, 32'(xfer_cnt[r]), 32'(target));
    endtask

    task automatic wait_rd(input int n, input string nm);
        bit ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge clk); #2;
            if (rd_log.size() >= n) ok = 1;
        end
        if (!ok) chk({nm, "_timeout"}, 32'(rd_log.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        logic [W-1:0] fair_exp[16];
        bubble = '0;
        do_reset();
        rd_en = 1'b1;

        // Single 3-beat packet from requester 2.
        chk("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);
        push_beat(2, 1'b0, 8'h21); push_beat(2, 1'b0, 8'h22); push_beat(2, 1'b1, 8'h23);
        @(posedge clk); #3;
        chk("t1_no_grant_yet", 32'(grant_valid), 32'd0);
        @(posedge clk); #3;
        chk("t1_grant_valid", 32'(grant_valid), 32'd1);
        chk("t1_grant_id", 32'(grant_id), 32'd2);
        for (int k = 0; k < 3; k++) begin
            chk("t1_wen", 32'(fifo_wen), 32'd1);
            chk("t1_wdata", 32'(fifo_wdata), 32'(8'h21 + k));
            @(posedge clk); #3;
        end
        chk("t1_wen_off", 32'(fifo_wen), 32'd0);
        chk("t1_released", 32'(grant_valid), 32'd0);
        wait_rd(3, "t1_rd");
        chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        for (int k = 0; k < 3; k++) chk("t1_rd_data", 32'(rd_log[k]), 32'(8'h21 + k));

        // Fairness: all four requesters with two 2-beat packets each.
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) begin
                push_beat(i, 1'b0, W'(i)); push_beat(i, 1'b1, W'(i));
            end
        for (int k = 0; k < 16; k++) fair_exp[k] = W'((k / 2) % 4);
        wait_rd(16, "t2_rd");
        for (int k = 0; k < 16; k++) chk("t2_rd_order", 32'(rd_log[k]), 32'(fair_exp[k]));
        chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd8);

        // Packet lock across a 2-cycle bubble with requester 0 waiting.
        do_reset();
        base = xfer_cnt[1];
        push_beat(1, 1'b0, 8'h11); push_beat(1, 1'b0, 8'h12);
        push_beat(1, 1'b0, 8'h13); push_beat(1, 1'b1, 8'h14);
        wait_grant("t3_grant");
        push_beat(0, 1'b0, 8'h01); push_beat(0, 1'b1, 8'h02);
        wait_xfer(1, base + 2, "t3_two_beats");
        bubble[1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t3_hold_id", 32'(grant_id), 32'd1);
            chk("t3_hold_valid", 32'(grant_valid), 32'd1);
            chk("t3_ready0", 32'(req_ready[0]), 32'd0);
            @(posedge clk); #2;
        end
        bubble[1] = 1'b0;
        wait_rd(6, "t3_rd");
        chk("t3_rd0", 32'(rd_log[0]), 32'h11);
        chk("t3_rd3", 32'(rd_log[3]), 32'h14);
        chk("t3_rd4", 32'(rd_log[4]), 32'h01);
        chk("t3_rd5", 32'(rd_log[5]), 32'h02);

        // Full backpressure: 10-beat packet into an 8-deep FIFO with the reader stalled.
        do_reset();
        rd_en = 1'b0;
        for (int k = 0; k < 10; k++) push_beat(0, (k == 9), W'(8'hA0 + k));
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t4_wen_cnt", 32'(wen_cnt), 32'd8);
        chk("t4_wfull", 32'(fifo_wfull), 32'd1);
        chk("t4_wen_off", 32'(fifo_wen), 32'd0);
        chk("t4_ready0", 32'(req_ready[0]), 32'd0);
        chk("t4_hold", 32'(grant_valid), 32'd1);
        rd_en = 1'b1;
        wait_rd(10, "t4_rd");
        for (int k = 0; k < 10; k++) chk("t4_rd_data", 32'(rd_log[k]), 32'(8'hA0 + k));
        chk("t4_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Admission: FIFO full, requester 3 waits for one free entry.
        do_reset();
        rd_en = 1'b0;
        for (int k = 0; k < 8; k++) push_beat(0, (k == 7), W'(8'hB0 + k));
        wait_xfer(0, xfer_cnt[0] + 8, "t5_fill");
        repeat (2) @(posedge clk);
        #2;
        chk("t5_level_full", 32'(fifo_wlevel), 32'd8);
        push_beat(3, 1'b1, 8'h3C);
        repeat (4) begin
            @(negedge clk);
            chk("t5_no_grant", 32'(grant_valid), 32'd0);
        end
        @(posedge clk); #2 rd_en = 1'b1;
        @(posedge clk); #2 rd_en = 1'b0;
        @(negedge clk);
        chk("t5_level7", 32'(fifo_wlevel), 32'd7);
        chk("t5_still_idle", 32'(grant_valid), 32'd0);
        @(negedge clk);
        chk("t5_granted", 32'(grant_valid), 32'd1);
        chk("t5_grant_id", 32'(grant_id), 32'd3);
        rd_en = 1'b1;
        wait_rd(9, "t5_drain");

        // Asynchronous reset during beat 2 of requester 1.
        do_reset();
        base = xfer_cnt[1];
        push_beat(3, 1'b0, 8'h31); push_beat(3, 1'b1, 8'h32);
        for (int k = 0; k < 4; k++) push_beat(1, (k == 3), W'(8'h41 + k));
        wait_xfer(1, base + 1, "t6_beat1");
        #1 arst = 1'b1;
        #1;
        chk("t6_gv_drop", 32'(grant_valid), 32'd0);
        chk("t6_ready_drop", 32'(req_ready), 32'd0);
        chk("t6_wen_drop", 32'(fifo_wen), 32'd0);
        chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd0);
        arst = 1'b0;
        wait_grant("t6_regrant");
        chk("t6_lowest_id", 32'(grant_id), 32'd1);
        repeat (30) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
